// File: rtl/aim65_tty_pkg.sv
// aim65_tty_pkg: shared constants, FSM state encodings and sizing helper for
// the AIM65 TTY bridge.
// Contents: UART_BITS, MIN_CLK_DIV, tx/rx state types + codes, baud_cnt_width().
package aim65_tty_pkg;

   localparam int UART_BITS   = 8;
   localparam int MIN_CLK_DIV = 4;

   // State codes are plain constants so that older tools and netlist
   // viewers keep displaying them as numbers.
   typedef logic [1:0] tx_state_t;
   localparam tx_state_t TX_IDLE  = 2'd0;
   localparam tx_state_t TX_START = 2'd1;
   localparam tx_state_t TX_DATA  = 2'd2;
   localparam tx_state_t TX_STOP  = 2'd3;

   typedef logic [1:0] rx_state_t;
   localparam rx_state_t RX_IDLE  = 2'd0;
   localparam rx_state_t RX_START = 2'd1;
   localparam rx_state_t RX_DATA  = 2'd2;
   localparam rx_state_t RX_STOP  = 2'd3;

   // Baud down-counter width: it only ever holds 0 .. clk_div-1.
   function automatic int baud_cnt_width(input int clk_div);
      return (clk_div < 2) ? 1 : $clog2(clk_div);
   endfunction

endpackage

// File: rtl/aim65_tty_fifo.sv
// aim65_tty_fifo: synchronous FIFO, extra pointer bit distinguishes full/empty.
// Latency: a pushed word is visible on o_pop_dat (and !o_empty) after one edge.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: i_clk, i_reset (sync, active-high), i_push/i_push_dat, i_pop/o_pop_dat,
//        o_full, o_empty, o_level (0 .. DEPTH).
module aim65_tty_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_dat,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_pop_dat,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop  && !o_empty;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_push_dat;
   end

   assign o_pop_dat = r_mem[r_rptr[AW-1:0]];
   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                      (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_level   = r_wptr - r_rptr;

endmodule

// File: rtl/aim65_tty_uart.sv
// aim65_tty_uart: 8N1 TTY bridge between host byte streams and the AIM65
// bit-banged serial lines (core tx_data -> host, host -> core rx_data).
// Latency: host handshake at edge E drives the start bit on o_tty_rx after E+2;
//          a received byte is presented at the stop-bit mid-sample edge.
// Backpressure: o_host_tx_ready = FIFO not full; received bytes are held
//          until taken, a byte arriving while one is held is dropped (o_rx_overrun).
// Ports: i_cpu_clk, i_reset (sync, active-high); host TX byte valid/ready;
//        host RX byte valid/ready; o_tty_rx (to core), i_tty_tx (from core,
//        asynchronous); o_rx_overrun / o_rx_frame_err pulses; o_tx_busy.
module aim65_tty_uart
   import aim65_tty_pkg::*;
#(
   parameter int CLK_DIV    = 104,
   parameter int FIFO_DEPTH = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic       i_cpu_clk,
   input  logic       i_reset,
   input  logic [7:0] i_host_tx_data,
   input  logic       i_host_tx_valid,
   output logic       o_host_tx_ready,
   output logic [7:0] o_host_rx_data,
   output logic       o_host_rx_valid,
   input  logic       i_host_rx_ready,
   output logic       o_tty_rx,
   input  logic       i_tty_tx,
   output logic       o_rx_overrun,
   output logic       o_rx_frame_err,
   output logic       o_tx_busy
);
   localparam int BW = baud_cnt_width(CLK_DIV);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BAUD_HALF = BW'(CLK_DIV / 2 - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(UART_BITS - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   if (CLK_DIV < MIN_CLK_DIV || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
      $error("CLK_DIV must be even and at least MIN_CLK_DIV");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two, at least 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("STOP_BITS must be 1 or 2");
   end

   // ---------------------------------------------------------------- TX path
   logic [UART_BITS-1:0] w_fifo_dat;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [LW-1:0]        w_fifo_level;
   logic                 w_fifo_pop;

   tx_state_t            r_tx_state;
   logic [BW-1:0]        r_tx_baud;
   logic [2:0]           r_tx_bit;
   logic [UART_BITS-1:0] r_tx_shift;
   logic                 r_tty_rx;
   logic                 r_tx_busy;
   logic                 w_tx_tick;
   logic                 w_tx_line;

   aim65_tty_fifo #(.WIDTH(UART_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .i_clk      (i_cpu_clk),
      .i_reset    (i_reset),
      .i_push     (i_host_tx_valid),
      .i_push_dat (i_host_tx_data),
      .i_pop      (w_fifo_pop),
      .o_pop_dat  (w_fifo_dat),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty),
      .o_level    (w_fifo_level)
   );

   assign w_tx_tick = (r_tx_baud == '0);

   // Pop from IDLE, or at the very end of the last stop bit so that
   // consecutive frames run back-to-back with no idle gap.
   always_comb begin
      w_fifo_pop = 1'b0;
      if (!w_fifo_empty) begin
         if (r_tx_state == TX_IDLE)
            w_fifo_pop = 1'b1;
         else if (r_tx_state == TX_STOP && w_tx_tick && r_tx_bit == STOP_LAST)
            w_fifo_pop = 1'b1;
      end
   end

   always_comb begin
      w_tx_line = 1'b1;
      case (r_tx_state)
         TX_START: w_tx_line = 1'b0;
         TX_DATA:  w_tx_line = r_tx_shift[0];
         default:  w_tx_line = 1'b1;
      endcase
   end

   always_ff @(posedge i_cpu_clk) begin
      if (i_reset) begin
         r_tx_state <= TX_IDLE;
         r_tx_baud  <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
      end else begin
         case (r_tx_state)
            TX_IDLE: begin
               if (w_fifo_pop) begin
                  r_tx_shift <= w_fifo_dat;
                  r_tx_baud  <= BAUD_LAST;
                  r_tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (w_tx_tick) begin
                  r_tx_baud  <= BAUD_LAST;
                  r_tx_bit   <= '0;
                  r_tx_state <= TX_DATA;
               end else begin
                  r_tx_baud <= r_tx_baud - 1'b1;
               end
            end
            TX_DATA: begin
               if (w_tx_tick) begin
                  r_tx_baud  <= BAUD_LAST;
                  r_tx_shift <= r_tx_shift >> 1;
                  if (r_tx_bit == BIT_LAST) begin
                     r_tx_bit   <= '0;
                     r_tx_state <= TX_STOP;
                  end else begin
                     r_tx_bit <= r_tx_bit + 3'd1;
                  end
               end else begin
                  r_tx_baud <= r_tx_baud - 1'b1;
               end
            end
            default: begin
               // r_tx_bit counts stop bits here.
               if (w_tx_tick) begin
                  r_tx_baud <= BAUD_LAST;
                  if (r_tx_bit == STOP_LAST) begin
                     r_tx_bit <= '0;
                     if (w_fifo_pop) begin
                        r_tx_shift <= w_fifo_dat;
                        r_tx_state <= TX_START;
                     end else begin
                        r_tx_state <= TX_IDLE;
                     end
                  end else begin
                     r_tx_bit <= r_tx_bit + 3'd1;
                  end
               end else begin
                  r_tx_baud <= r_tx_baud - 1'b1;
               end
            end
         endcase
      end
   end

   // Registered line and busy flag: glitch-free output, and busy stays
   // aligned with the line it describes.
   always_ff @(posedge i_cpu_clk) begin
      if (i_reset) begin
         r_tty_rx  <= 1'b1;
         r_tx_busy <= 1'b0;
      end else begin
         r_tty_rx  <= w_tx_line;
         r_tx_busy <= (w_fifo_level != '0) || (r_tx_state != TX_IDLE);
      end
   end

   assign o_tty_rx        = r_tty_rx;
   assign o_tx_busy       = r_tx_busy;
   assign o_host_tx_ready = !w_fifo_full;

   // ---------------------------------------------------------------- RX path
   logic                 r_rx_sync1;
   logic                 r_rx_sync2;
   logic                 r_rx_prev;
   rx_state_t            r_rx_state;
   logic [BW-1:0]        r_rx_baud;
   logic [2:0]           r_rx_bit;
   logic [UART_BITS-1:0] r_rx_shift;
   logic [UART_BITS-1:0] r_host_rx_data;
   logic                 r_host_rx_valid;
   logic                 r_rx_overrun;
   logic                 r_rx_frame_err;
   logic                 w_rx_tick;
   logic                 w_rx_fall;
   logic                 w_rx_deliver;
   logic                 w_rx_bad_stop;

   assign w_rx_tick     = (r_rx_baud == '0);
   assign w_rx_fall     = r_rx_prev && !r_rx_sync2;
   assign w_rx_deliver  = (r_rx_state == RX_STOP) && w_rx_tick &&  r_rx_sync2;
   assign w_rx_bad_stop = (r_rx_state == RX_STOP) && w_rx_tick && !r_rx_sync2;

   always_ff @(posedge i_cpu_clk) begin
      if (i_reset) begin
         r_rx_sync1 <= 1'b1;
         r_rx_sync2 <= 1'b1;
         r_rx_prev  <= 1'b1;
      end else begin
         r_rx_sync1 <= i_tty_tx;
         r_rx_sync2 <= r_rx_sync1;
         r_rx_prev  <= r_rx_sync2;
      end
   end

   // IDLE is edge-triggered: after a bad stop bit the FSM goes straight back
   // to IDLE, and a line still held low cannot start a frame until it has
   // returned high and fallen again.
   always_ff @(posedge i_cpu_clk) begin
      if (i_reset) begin
         r_rx_state <= RX_IDLE;
         r_rx_baud  <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         case (r_rx_state)
            RX_IDLE: begin
               if (w_rx_fall) begin
                  r_rx_baud  <= BAUD_HALF;
                  r_rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (w_rx_tick) begin
                  if (r_rx_sync2) begin
                     r_rx_state <= RX_IDLE;   // glitch shorter than half a bit
                  end else begin
                     r_rx_baud  <= BAUD_LAST;
                     r_rx_bit   <= '0;
                     r_rx_state <= RX_DATA;
                  end
               end else begin
                  r_rx_baud <= r_rx_baud - 1'b1;
               end
            end
            RX_DATA: begin
               if (w_rx_tick) begin
                  r_rx_baud  <= BAUD_LAST;
                  r_rx_shift <= {r_rx_sync2, r_rx_shift[UART_BITS-1:1]};
                  if (r_rx_bit == BIT_LAST)
                     r_rx_state <= RX_STOP;
                  else
                     r_rx_bit <= r_rx_bit + 3'd1;
               end else begin
                  r_rx_baud <= r_rx_baud - 1'b1;
               end
            end
            default: begin
               // Leave at mid stop bit so the next start edge can be caught
               // in the second half of the stop bit.
               if (w_rx_tick)
                  r_rx_state <= RX_IDLE;
               else
                  r_rx_baud <= r_rx_baud - 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge i_cpu_clk) begin
      if (i_reset) begin
         r_host_rx_data  <= '0;
         r_host_rx_valid <= 1'b0;
         r_rx_overrun    <= 1'b0;
         r_rx_frame_err  <= 1'b0;
      end else begin
         r_rx_overrun   <= 1'b0;
         r_rx_frame_err <= w_rx_bad_stop;
         if (w_rx_deliver) begin
            // A byte taken this same cycle frees the holder for the new one.
            if (!r_host_rx_valid || i_host_rx_ready) begin
               r_host_rx_data  <= r_rx_shift;
               r_host_rx_valid <= 1'b1;
            end else begin
               r_rx_overrun <= 1'b1;
            end
         end else if (r_host_rx_valid && i_host_rx_ready) begin
            r_host_rx_valid <= 1'b0;
         end
      end
   end

   assign o_host_rx_data  = r_host_rx_data;
   assign o_host_rx_valid = r_host_rx_valid;
   assign o_rx_overrun    = r_rx_overrun;
   assign o_rx_frame_err  = r_rx_frame_err;

endmodule
